// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory port arbiter: FSM state
//   encoding, master identifiers, word-offset width and an alignment helper.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      PRI_CORE  = 1'b0,
      FORCE_DBG = 1'b1
   } arb_state_e;

   localparam logic MST_CORE = 1'b0;
   localparam logic MST_DBG  = 1'b1;

   localparam int WORD_OFFSET_BITS = 2;

   // A word access is misaligned when any byte-offset bit is set.
   function automatic logic is_misaligned(input logic [WORD_OFFSET_BITS-1:0] lo);
      return lo != '0;
   endfunction

endpackage

// File: rtl/dmem_starve_timer.sv
// dmem_starve_timer
//   Counts consecutive cycles in which dbg requests but is denied, and
//   raises o_force_next on the denial that must be followed by a forced
//   dbg slot.
//   Ports:
//     i_clk, i_rst_n   clock, async active-low reset
//     i_dbg_req        dbg request
//     i_dbg_gnt        dbg granted this cycle
//     o_force_next     next cycle must be a forced dbg slot
module dmem_starve_timer #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_dbg_req,
   input  logic i_dbg_gnt,
   output logic o_force_next
);

   localparam int            CW     = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM    = CW'(STARVE_LIMIT);
   localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

   logic [CW-1:0] r_wait_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wait_cnt <= '0;
      end else if (!i_dbg_req || i_dbg_gnt) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != LIM) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // This denial is the STARVE_LIMIT-th in a row.
   assign o_force_next = i_dbg_req & ~i_dbg_gnt & (r_wait_cnt == LIM_M1);

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the MEM stage (core, priority)
//   and a debug/loader master (dbg) with guaranteed forward progress.
//   Ports:
//     i_clk, i_rst_n                  clock, async active-low reset
//     i_core_*  / o_core_*            core request, grant, stall, comb. read data, misalign flag
//     i_dbg_*   / o_dbg_*             dbg request, grant, registered done/err/read data
//     o_mem_*   / i_mem_rdata         data-memory control, address, write data, read data
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_core_req,
   input  logic              i_core_we,
   input  logic [ADDR_W-1:0] i_core_addr,
   input  logic [DATA_W-1:0] i_core_wdata,
   output logic              o_core_gnt,
   output logic              o_core_stall,
   output logic [DATA_W-1:0] o_core_rdata,
   output logic              o_core_misalign,
   input  logic              i_dbg_req,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic              o_dbg_gnt,
   output logic              o_dbg_done,
   output logic              o_dbg_err,
   output logic [DATA_W-1:0] o_dbg_rdata,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic [0:0] ST_PRI_CORE  = PRI_CORE;
   localparam logic [0:0] ST_FORCE_DBG = FORCE_DBG;

   logic [0:0]        r_state;
   logic              w_force_next;
   logic              w_core_gnt;
   logic              w_dbg_gnt;
   logic              w_any_gnt;
   logic              w_sel;
   logic              w_we;
   logic              w_mis;
   logic              w_dbg_mis;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              r_dbg_done;
   logic              r_dbg_err;
   logic [DATA_W-1:0] r_dbg_rdata;

   // Grants are qualified by i_rst_n so nothing reaches memory while in reset.
   // In the forced slot dbg wins only if it still requests; otherwise the core
   // keeps the port so the slot is not wasted.
   assign w_dbg_gnt  = i_rst_n & i_dbg_req & ((r_state == ST_FORCE_DBG) | ~i_core_req);
   assign w_core_gnt = i_rst_n & i_core_req & ~w_dbg_gnt;
   assign w_any_gnt  = w_core_gnt | w_dbg_gnt;

   dmem_starve_timer #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_timer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_dbg_req    (i_dbg_req),
      .i_dbg_gnt    (w_dbg_gnt),
      .o_force_next (w_force_next)
   );

   // Forced slot lasts exactly one cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_PRI_CORE;
      end else if ((r_state == ST_PRI_CORE) && w_force_next) begin
         r_state <= ST_FORCE_DBG;
      end else begin
         r_state <= ST_PRI_CORE;
      end
   end

   // Memory mux.
   assign w_sel   = w_dbg_gnt ? MST_DBG : MST_CORE;
   assign w_addr  = (w_sel == MST_DBG) ? i_dbg_addr  : i_core_addr;
   assign w_wdata = (w_sel == MST_DBG) ? i_dbg_wdata : i_core_wdata;
   assign w_we    = (w_sel == MST_DBG) ? i_dbg_we    : i_core_we;
   assign w_mis   = is_misaligned(w_addr[WORD_OFFSET_BITS-1:0]);

   assign o_mem_addr  = w_any_gnt ? w_addr  : '0;
   assign o_mem_wdata = w_any_gnt ? w_wdata : '0;
   assign o_mem_read  = w_any_gnt & ~w_we;
   assign o_mem_write = w_any_gnt & w_we & ~w_mis;

   // Core side: combinational, so the MEM stage timing is unchanged.
   assign o_core_gnt      = w_core_gnt;
   assign o_core_stall    = i_rst_n & i_core_req & ~w_core_gnt;
   assign o_core_rdata    = (w_core_gnt & ~i_core_we) ? i_mem_rdata : '0;
   assign o_core_misalign = w_core_gnt & is_misaligned(i_core_addr[WORD_OFFSET_BITS-1:0]);

   // Dbg side: registered response one cycle after the grant.
   assign w_dbg_mis = is_misaligned(i_dbg_addr[WORD_OFFSET_BITS-1:0]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dbg_done  <= 1'b0;
         r_dbg_err   <= 1'b0;
         r_dbg_rdata <= '0;
      end else begin
         r_dbg_done <= w_dbg_gnt;
         r_dbg_err  <= w_dbg_gnt & w_dbg_mis;
         if (w_dbg_gnt && !i_dbg_we && !w_dbg_mis) begin
            r_dbg_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_dbg_gnt   = w_dbg_gnt;
   assign o_dbg_done  = r_dbg_done;
   assign o_dbg_err   = r_dbg_err;
   assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed scenarios with literal expectations, then randomized traffic
//   checked every cycle against a behavioural model (denial count + shadow
//   memory) of the arbiter.
module tb_dmem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_req = 1'b0, core_we = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] dbg_addr = '0, dbg_wdata = '0;
   logic        core_gnt, core_stall, core_misalign;
   logic [31:0] core_rdata;
   logic        dbg_gnt, dbg_done, dbg_err;
   logic [31:0] dbg_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
      .i_core_wdata(core_wdata), .o_core_gnt(core_gnt), .o_core_stall(core_stall),
      .o_core_rdata(core_rdata), .o_core_misalign(core_misalign),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_wdata(dbg_wdata), .o_dbg_gnt(dbg_gnt), .o_dbg_done(dbg_done),
      .o_dbg_err(dbg_err), .o_dbg_rdata(dbg_rdata),
      .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   // Data memory driven by the DUT (64 words).
   logic [31:0] mem [64];
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

   // ---------------- behavioural model ----------------
   logic [31:0] ref_mem [64];
   int          denied = 0;  // consecutive cycles dbg asked and was refused
   logic        m_done = 1'b0, m_err = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        e_core_gnt, e_dbg_gnt, e_stall, e_mis, e_mrd, e_mwr;
   logic [31:0] e_maddr, e_mwdata, e_core_rdata;

   always_comb begin
      // dbg wins once it has been refused LIMIT times in a row, or if core is idle
      e_dbg_gnt    = rst_n && dbg_req && (denied >= LIMIT || !core_req);
      e_core_gnt   = rst_n && core_req && !e_dbg_gnt;
      e_stall      = rst_n && core_req && !e_core_gnt;
      e_mis        = e_core_gnt && (core_addr[1:0] != 2'b00);
      e_mrd        = (e_core_gnt && !core_we) || (e_dbg_gnt && !dbg_we);
      e_mwr        = (e_core_gnt && core_we && core_addr[1:0] == 2'b00) ||
                     (e_dbg_gnt && dbg_we && dbg_addr[1:0] == 2'b00);
      e_maddr      = e_core_gnt ? core_addr  : (e_dbg_gnt ? dbg_addr  : 32'h0);
      e_mwdata     = e_core_gnt ? core_wdata : (e_dbg_gnt ? dbg_wdata : 32'h0);
      e_core_rdata = (e_core_gnt && !core_we) ? ref_mem[core_addr[7:2]] : 32'h0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         denied <= 0;
         m_done <= 1'b0;
         m_err  <= 1'b0;
         m_rdata <= '0;
      end else begin
         denied <= (dbg_req && !e_dbg_gnt) ? denied + 1 : 0;
         m_done <= e_dbg_gnt;
         m_err  <= e_dbg_gnt && (dbg_addr[1:0] != 2'b00);
         if (e_dbg_gnt && !dbg_we && dbg_addr[1:0] == 2'b00) m_rdata <= ref_mem[dbg_addr[7:2]];
         if (e_mwr) ref_mem[e_maddr[7:2]] <= e_mwdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
   endtask

   // Compare process: every cycle, 1 time unit after inputs change.
   always @(negedge clk) begin
      #1;
      chk("core_gnt",  32'(core_gnt),      32'(e_core_gnt));
      chk("core_stall",32'(core_stall),    32'(e_stall));
      chk("core_mis",  32'(core_misalign), 32'(e_mis));
      chk("core_rdata",core_rdata,         e_core_rdata);
      chk("dbg_gnt",   32'(dbg_gnt),       32'(e_dbg_gnt));
      chk("dbg_done",  32'(dbg_done),      32'(m_done));
      chk("dbg_err",   32'(dbg_err),       32'(m_err));
      chk("dbg_rdata", dbg_rdata,          m_rdata);
      chk("mem_read",  32'(mem_read),      32'(e_mrd));
      chk("mem_write", 32'(mem_write),     32'(e_mwr));
      chk("mem_addr",  mem_addr,           e_maddr);
      chk("mem_wdata", mem_wdata,          e_mwdata);
   end

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = {24'h0, 6'($urandom), 2'b00};
      if ($urandom % 6 == 0) a[1:0] = 2'($urandom);
      return a;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic was_gnt;
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[0] = 32'd21;          ref_mem[0] = 32'd21;
      mem[6] = 32'h1234_5678;   ref_mem[6] = 32'h1234_5678;

      // Reset with a core write pending.
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h14; core_wdata = 32'hAA;
      @(negedge clk); #2;
      chk("rst_mem_write", 32'(mem_write), 32'h0);
      chk("rst_core_gnt",  32'(core_gnt),  32'h0);
      chk("rst_dbg_gnt",   32'(dbg_gnt),   32'h0);
      chk("rst_dbg_done",  32'(dbg_done),  32'h0);
      @(negedge clk); rst_n = 1'b1; #2;
      chk("rel_core_gnt",  32'(core_gnt),  32'h1);
      chk("rel_mem_write", 32'(mem_write), 32'h1);
      // Core read back.
      @(negedge clk); core_we = 1'b0; #2;
      chk("core_rd_AA",    core_rdata,       32'hAA);
      chk("core_no_stall", 32'(core_stall),  32'h0);

      // Dbg-only read of word 0.
      @(negedge clk); core_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0; #2;
      chk("dbg_rd_gnt",    32'(dbg_gnt),  32'h1);
      @(negedge clk); dbg_req = 1'b0; #2;
      chk("dbg_rd_done",   32'(dbg_done), 32'h1);
      chk("dbg_rd_data",   dbg_rdata,     32'd21);
      chk("dbg_rd_err",    32'(dbg_err),  32'h0);

      // Starvation: denied cycles 0-3, forced at cycle 4.
      @(negedge clk); core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
      dbg_req = 1'b1; dbg_addr = 32'h4;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #2;
         chk("starve_dbg_gnt",  32'(dbg_gnt),    32'(i == 4));
         chk("starve_stall",    32'(core_stall), 32'(i == 4));
      end
      @(negedge clk); dbg_req = 1'b0; #2;
      chk("starve_core_back", 32'(core_gnt), 32'h1);

      // Misaligned dbg write, then core reads.
      @(negedge clk); core_req = 1'b0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1A; dbg_wdata = 32'h55; #2;
      chk("mis_dbg_gnt",   32'(dbg_gnt),   32'h1);
      chk("mis_mem_write", 32'(mem_write), 32'h0);
      @(negedge clk); dbg_req = 1'b0; dbg_we = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h18; #2;
      chk("mis_dbg_done",  32'(dbg_done), 32'h1);
      chk("mis_dbg_err",   32'(dbg_err),  32'h1);
      chk("mis_old_value", core_rdata,    32'h1234_5678);
      @(negedge clk); core_addr = 32'h03; #2;
      chk("core_misalign", 32'(core_misalign), 32'h1);
      chk("core_mis_rdata", core_rdata,        32'd21);

      // Reset hitting the forced slot.
      @(negedge clk); core_addr = 32'h20; dbg_req = 1'b1; dbg_addr = 32'h4;
      for (int i = 0; i < 3; i++) @(negedge clk);
      @(negedge clk); rst_n = 1'b0; #2;
      chk("rstf_dbg_gnt",  32'(dbg_gnt),  32'h0);
      chk("rstf_core_gnt", 32'(core_gnt), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #2;
         chk("rstf_dbg_gnt_after", 32'(dbg_gnt), 32'(i == 4));
      end
      @(negedge clk); dbg_req = 1'b0; core_req = 1'b0;

      // Randomized traffic.
      was_gnt = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = ($urandom % 150 != 0);
         core_req   = ($urandom % 10) < 6;
         core_we    = $urandom % 2;
         core_addr  = rand_addr();
         core_wdata = $urandom;
         if (dbg_req && was_gnt) begin
            dbg_req = 1'b0;
         end else if (!dbg_req && ($urandom % 3 == 0)) begin
            dbg_req   = 1'b1;
            dbg_we    = $urandom % 2;
            dbg_addr  = rand_addr();
            dbg_wdata = $urandom;
         end
         #2;
         was_gnt = dbg_gnt;
      end

      @(negedge clk); #3;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
